// File: rtl/rv32i_alu_arbiter.sv
// Two-port arbiter sharing one RV32I ALU.
// One op in flight; result registered and returned to its owner.
module rv32i_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  op_i,
  output logic [31:0] res_o
);

  logic [4:0] sh;
  assign sh = b_i[4:0];

  always_comb begin
    res_o = '0;
    unique case (op_i)
      4'b0000: res_o = a_i + b_i;
      4'b0001: res_o = a_i - b_i;
      4'b0010: res_o = a_i & b_i;
      4'b0011: res_o = a_i | b_i;
      4'b0100: res_o = a_i ^ b_i;
      4'b0101: res_o = a_i << sh;
      4'b0110: res_o = a_i >> sh;
      4'b0111: res_o = $unsigned($signed(a_i) >>> sh);
      4'b1000: res_o = {31'd0, $signed(a_i) < $signed(b_i)};
      4'b1001: res_o = {31'd0, a_i < b_i};
      default: res_o = '0;
    endcase
  end

endmodule

module rv32i_alu_arbiter #(
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_zero,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [31:0]      res_q, res_d;
  logic             zero_q, zero_d;
  logic             pref_q, pref_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic        done, free;
  logic        gnt0, gnt1, hs;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;

  // done: owner consumes the held response this cycle
  assign done = (state_q == HOLD) &&
                (owner_q ? rsp1_ready : rsp0_ready);
  assign free = rst_n && ((state_q == IDLE) || done);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (free) begin
      unique case (1'b1)
        req0_valid && req1_valid: begin
          if (PRIO_MODE != 0 || !pref_q) gnt0 = 1'b1;
          else                           gnt1 = 1'b1;
        end
        req0_valid && !req1_valid: gnt0 = 1'b1;
        req1_valid && !req0_valid: gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign hs     = gnt0 | gnt1;
  assign alu_a  = gnt1 ? req1_a  : req0_a;
  assign alu_b  = gnt1 ? req1_b  : req0_b;
  assign alu_op = gnt1 ? req1_op : req0_op;

  rv32i_alu u_alu (
    .a_i  (alu_a),
    .b_i  (alu_b),
    .op_i (alu_op),
    .res_o(alu_res)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    res_d   = res_q;
    zero_d  = zero_q;
    pref_d  = pref_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (done) begin
      state_d = IDLE;
      if (!owner_q && cnt0_q != '1)
        cnt0_d = cnt0_q + CNT_W'(1);
      if (owner_q && cnt1_q != '1)
        cnt1_d = cnt1_q + CNT_W'(1);
    end
    if (hs) begin
      state_d = HOLD;
      owner_d = gnt1;
      res_d   = alu_res;
      zero_d  = (alu_res == '0);
      pref_d  = ~gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      pref_q  <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      pref_q  <= pref_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign busy        = (state_q == HOLD);
  assign rsp0_valid  = busy && !owner_q;
  assign rsp1_valid  = busy && owner_q;
  assign rsp0_result = res_q;
  assign rsp1_result = res_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign cnt0        = cnt0_q;
  assign cnt1        = cnt1_q;

endmodule

// File: tb/tb_rv32i_alu_arbiter.sv
// Bench for rv32i_alu_arbiter: round-robin and fixed-priority
// instances checked against a transaction-level model.
module tb_rv32i_alu_arbiter;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        rv   [2][2];
  logic        rr   [2][2];
  logic [31:0] ra   [2][2];
  logic [31:0] rb   [2][2];
  logic [3:0]  rop  [2][2];
  logic        sv   [2][2];
  logic        srdy [2][2];
  logic [31:0] sres [2][2];
  logic        sz   [2][2];
  logic        bsy  [2];
  logic [CW-1:0] cnt [2][2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rv32i_alu_arbiter #(.PRIO_MODE(g), .CNT_W(CW)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (rv[g][0]),
      .req0_ready (rr[g][0]),
      .req0_a     (ra[g][0]),
      .req0_b     (rb[g][0]),
      .req0_op    (rop[g][0]),
      .req1_valid (rv[g][1]),
      .req1_ready (rr[g][1]),
      .req1_a     (ra[g][1]),
      .req1_b     (rb[g][1]),
      .req1_op    (rop[g][1]),
      .rsp0_valid (sv[g][0]),
      .rsp0_ready (srdy[g][0]),
      .rsp0_result(sres[g][0]),
      .rsp0_zero  (sz[g][0]),
      .rsp1_valid (sv[g][1]),
      .rsp1_ready (srdy[g][1]),
      .rsp1_result(sres[g][1]),
      .rsp1_zero  (sz[g][1]),
      .busy       (bsy[g]),
      .cnt0       (cnt[g][0]),
      .cnt1       (cnt[g][1])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_m(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int s;
    s = int'(b[4:0]);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return a >> s;
      4'd7: return (a >> s) |
                   (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      4'd8: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000))
                   ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // model: pending response per instance, tie preference, counts
  logic        mpend [2], npend [2];
  logic        mown  [2], nown  [2];
  logic        mpref [2], npref [2];
  logic [31:0] mres  [2], nres  [2];
  int          mcnt  [2][2], ncnt [2][2];
  bit          m_free;
  int          m_gnt;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst_n) begin
        mpend[g] = 0; npend[g] = 0;
        mown[g]  = 0; nown[g]  = 0;
        mpref[g] = 0; npref[g] = 0;
        for (int p = 0; p < 2; p++) begin
          mcnt[g][p] = 0; ncnt[g][p] = 0;
          chk($sformatf("i%0d rst rsp_valid%0d", g, p), sv[g][p], 0);
          chk($sformatf("i%0d rst req_ready%0d", g, p), rr[g][p], 0);
          chk($sformatf("i%0d rst cnt%0d", g, p), cnt[g][p], 0);
        end
        chk($sformatf("i%0d rst busy", g), bsy[g], 0);
      end else begin
        m_free = !mpend[g] || srdy[g][mown[g]];
        m_gnt  = -1;
        if (m_free) begin
          if (rv[g][0] && rv[g][1])
            m_gnt = (g == 1) ? 0 : int'(mpref[g]);
          else if (rv[g][0]) m_gnt = 0;
          else if (rv[g][1]) m_gnt = 1;
        end
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("i%0d req_ready%0d", g, p),
              rr[g][p], m_gnt == p);
          chk($sformatf("i%0d rsp_valid%0d", g, p),
              sv[g][p], mpend[g] && (int'(mown[g]) == p));
          chk($sformatf("i%0d cnt%0d", g, p), cnt[g][p], mcnt[g][p]);
        end
        chk($sformatf("i%0d busy", g), bsy[g], mpend[g]);
        if (mpend[g]) begin
          chk($sformatf("i%0d result", g), sres[g][mown[g]], mres[g]);
          chk($sformatf("i%0d zero", g), sz[g][mown[g]], mres[g] == 0);
        end
        npend[g] = mpend[g]; nown[g] = mown[g];
        npref[g] = mpref[g]; nres[g] = mres[g];
        ncnt[g]  = mcnt[g];
        if (mpend[g] && srdy[g][mown[g]]) begin
          if (ncnt[g][mown[g]] < (1 << CW) - 1)
            ncnt[g][mown[g]]++;
          npend[g] = 0;
        end
        if (m_gnt >= 0) begin
          npend[g] = 1;
          nown[g]  = (m_gnt == 1);
          npref[g] = (m_gnt == 0);
          nres[g]  = alu_m(rop[g][m_gnt], ra[g][m_gnt], rb[g][m_gnt]);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      mpend = npend; mown = nown; mpref = npref;
      mres  = nres;  mcnt = ncnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < 2; g++)
      for (int p = 0; p < 2; p++) begin
        rv[g][p] = 0; ra[g][p] = 0; rb[g][p] = 0;
        rop[g][p] = 0; srdy[g][p] = 1;
      end
  endtask

  task automatic set_req(input int g, input int p, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    rv[g][p] = 1; rop[g][p] = op; ra[g][p] = a; rb[g][p] = b;
  endtask

  task automatic issue(input int g, input int p, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string nm);
    int n = 0;
    set_req(g, p, op, a, b);
    @(negedge clk);
    while (!rr[g][p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " grant"}, rr[g][p], 1);
    tick();
    rv[g][p] = 0;
    @(negedge clk);
    chk({nm, " valid"}, sv[g][p], 1);
    chk({nm, " result"}, sres[g][p], exp);
    chk({nm, " zero"}, sz[g][p], exp == 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  bit acc [2][2];
  int exp_p, prev;

  initial begin
    rst_n = 0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy0", bsy[0], 0);
    chk("reset cnt00", cnt[0][0], 0);
    @(posedge clk);
    #1 rst_n = 1;

    issue(0, 0, 4'd0, 32'd5, 32'd7, 32'd12, "add 5+7");
    tick();
    @(negedge clk);
    chk("add cnt0", cnt[0][0], 1);
    chk("add idle busy", bsy[0], 0);
    tick();

    set_req(0, 0, 4'd0, 32'd10, 32'd20);
    set_req(0, 1, 4'd1, 32'd3, 32'd3);
    exp_p = 1;
    prev  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt grant0", rr[0][0], exp_p == 0);
      chk("alt grant1", rr[0][1], exp_p == 1);
      if (i > 0) begin
        chk("alt rsp valid", sv[0][prev], 1);
        chk("alt rsp result", sres[0][prev], prev ? 0 : 30);
        chk("alt rsp zero", sz[0][prev], prev == 1);
      end
      tick();
      prev  = exp_p;
      exp_p = 1 - exp_p;
    end
    rv[0][0] = 0;
    rv[0][1] = 0;
    @(negedge clk);
    chk("alt last valid", sv[0][prev], 1);
    chk("alt last result", sres[0][prev], prev ? 0 : 30);
    tick();

    issue(0, 1, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt");
    tick();
    issue(0, 1, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, "sltu");
    tick();
    issue(0, 1, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    tick();

    srdy[0][0] = 0;
    issue(0, 0, 4'd0, 32'd1, 32'd1, 32'd2, "bp add");
    tick();
    set_req(0, 0, 4'd4, 32'd6, 32'd3);
    set_req(0, 1, 4'd3, 32'd8, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp hold valid", sv[0][0], 1);
      chk("bp hold data", sres[0][0], 2);
      chk("bp ready0", rr[0][0], 0);
      chk("bp ready1", rr[0][1], 0);
      tick();
    end
    srdy[0][0] = 1;
    @(negedge clk);
    chk("bp release valid", sv[0][0], 1);
    chk("bp release grant1", rr[0][1], 1);
    tick();
    rv[0][1] = 0;
    @(negedge clk);
    chk("bp or valid", sv[0][1], 1);
    chk("bp or result", sres[0][1], 9);
    chk("bp next grant0", rr[0][0], 1);
    tick();
    rv[0][0] = 0;
    @(negedge clk);
    chk("bp xor result", sres[0][0], 5);
    tick();

    set_req(1, 0, 4'd0, 32'd1, 32'd2);
    set_req(1, 1, 4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("prio grant0", rr[1][0], 1);
      chk("prio grant1", rr[1][1], 0);
      tick();
    end
    rv[1][0] = 0;
    rv[1][1] = 0;
    tick();
    tick();

    srdy[0][0] = 0;
    issue(0, 0, 4'd0, 32'd9, 32'd9, 32'd18, "pre rst");
    tick();
    rst_n = 0;
    #1;
    chk("rst drop valid", sv[0][0], 0);
    chk("rst drop busy", bsy[0], 0);
    chk("rst drop cnt0", cnt[0][0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    srdy[0][0] = 1;
    set_req(0, 0, 4'd15, 32'd123, 32'd456);
    set_req(0, 1, 4'd0, 32'd1, 32'd1);
    @(negedge clk);
    chk("post rst grant0", rr[0][0], 1);
    tick();
    rv[0][0] = 0;
    @(negedge clk);
    chk("op1111 valid", sv[0][0], 1);
    chk("op1111 result", sres[0][0], 0);
    chk("op1111 zero", sz[0][0], 1);
    tick();
    rv[0][1] = 0;
    tick();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        for (int p = 0; p < 2; p++)
          acc[g][p] = rv[g][p] && rr[g][p];
      tick();
      for (int g = 0; g < 2; g++)
        for (int p = 0; p < 2; p++) begin
          if (!rv[g][p] || acc[g][p]) begin
            rv[g][p]  = ($urandom_range(0, 3) != 0);
            rop[g][p] = 4'($urandom_range(0, 15));
            ra[g][p]  = pick();
            rb[g][p]  = pick();
          end
          srdy[g][p] = ($urandom_range(0, 3) != 0);
        end
    end

    idle_all();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
